msdap_conv_sequencer: RTL and testbench
=======================================

Name: msdap_conv_sequencer

Overview:
- Per-channel scheduler for the MSDAP filter datapath.
- On each new input sample it walks the 16-entry Rj table and the 512-entry coefficient memory, fetches the matching history samples from the 256-entry circular data buffer, and accumulates the 40-bit shift-and-add result.
- One instance is used per channel (L, R). Both are started from the top-level FSM working state when a sample word completes.

Parameters:
- RJ_NUM, 16, number of Rj groups.
- COEFF_NUM, 512, coefficient memory depth.
- DATA_NUM, 256, data buffer depth (circular).
- ACC_W, 40, accumulator/result width.
- FRAC_SH, 16, left alignment applied to input samples before accumulation.

Ports:
- sClk input 1: system clock.
- reset input 1: asynchronous, active-high reset.
- clear input 1: synchronous abort to IDLE (sleep/clear mode).
- start input 1: one-cycle request to compute output for sample n.
- n_in input 16: current sample index (0-based, since last clear).
- newest_ptr input 8: data buffer address holding x(n).
- rj_addr output 4: Rj table read address.
- rj_data input 16: Rj value, valid one cycle after rj_addr.
- coeff_addr output 9: coefficient read address.
- coeff_data input 16: coefficient, valid one cycle after coeff_addr. Bit 8 is sign (1 = subtract); bits 7:0 are offset k.
- data_rd_en output 1: data buffer read strobe.
- data_addr output 8: data buffer read address.
- data_rd input 16: signed sample, valid one cycle after data_rd_en.
- busy output 1: high from start acceptance to done.
- done output 1: one-cycle pulse when result is updated.
- result output 40: signed output y(n), held until next done.
- coeff_overrun output 1: sticky; set when the Rj sum exceeds COEFF_NUM.

Behaviour:
- Reset (async) or clear (sync): state IDLE. busy, done, data_rd_en, coeff_overrun = 0. result = 0. All addresses = 0. Accumulator = 0.
- In IDLE, start latches n_in and newest_ptr, zeroes the accumulator, zeroes the coefficient pointer and j, then moves to RJ_FETCH. start while busy is ignored.
- RJ_FETCH (1 cycle): rj_addr = j.
- RJ_LATCH (1 cycle): latch remaining count r = rj_data. If r = 0, go to SHIFT; else go to COEF_FETCH.
- COEF_FETCH (1 cycle): coeff_addr = coefficient pointer.
- COEF_LATCH (1 cycle):
  - Decode sign s and offset k.
  - If k <= n (latched): data_rd_en = 1 and data_addr = (newest_ptr - k) mod 256 (wrap-around).
  - Else: no read; the term contributes zero.
- DATA_ACC (1 cycle):
  - If the read was issued: acc = acc ± (sign-extended data_rd << FRAC_SH), truncated to 40 bits (two's complement wrap, no saturation).
  - Coefficient pointer += 1; r -= 1.
  - If r = 0, go to SHIFT; else go to COEF_FETCH.
- SHIFT (1 cycle): acc = acc >>> 1 (arithmetic). If j = 15, go to DONE; else j += 1 and go to RJ_FETCH.
- DONE (1 cycle): result = acc, done = 1, busy drops, next state IDLE. A start in the DONE cycle is ignored. A start in the cycle after DONE is accepted.
- Timing: term cost is fixed at 3 cycles regardless of offset validity. With C = ΣRj, done is asserted in cycle 49 + 3C after the start cycle (start cycle = 0).
- Overrun: if the coefficient pointer would reach COEFF_NUM with r > 0, set coeff_overrun. All remaining terms are treated as zero without reads, and group/shift timing is unchanged.
- Reset mid-operation: result returns to 0 immediately; no done pulse.
- clear mid-operation: abort the same cycle; result keeps its last value, done is not pulsed.

Test Plan:
- All rj = 0, start with n = 0 → done at cycle 49, result = 0x0000000000, no data_rd_en pulses.
- rj[0] = 1, others 0; coeff[0] = 0x0000; x(0) = 0x0100; n = 0 → result = 0x0000000100 (16 shifts), done at cycle 52.
- Same as previous with coeff[0] = 0x0100 (negative) → result = 0xFFFFFFFF00.
- rj[15] = 1 only; coeff[0] = 0x0000; x = 0x0100 → result = 0x0000800000 (one shift).
- coeff[0] = 0x0005, n = 3 → no data_rd_en, result = 0. With newest_ptr = 2 and n = 300, data_addr = 0xFD (wrap-around).
- Rj sum = 520 → coeff_overrun = 1, done at 49 + 1560 cycles. A start issued mid-run is ignored. clear mid-run leads to IDLE the next cycle with no done.

Source files
------------

// File: rtl/msdap_conv_sequencer_if.sv
// Memory-side bus of the MSDAP convolution sequencer.
// Groups the three synchronous-read table ports: Rj table, coefficient
// memory and the circular data buffer. Read data is valid one cycle
// after its address/strobe.
//   master : the sequencer (drives addresses and read strobe)
//   slave  : the memories (drive read data)
interface msdap_conv_sequencer_if;
  logic [3:0]  rj_addr;
  logic [15:0] rj_data;
  logic [8:0]  coeff_addr;
  logic [15:0] coeff_data;
  logic        data_rd_en;
  logic [7:0]  data_addr;
  logic [15:0] data_rd;

  modport master (
    output rj_addr, coeff_addr, data_rd_en, data_addr,
    input  rj_data, coeff_data, data_rd
  );

  modport slave (
    input  rj_addr, coeff_addr, data_rd_en, data_addr,
    output rj_data, coeff_data, data_rd
  );
endinterface

// File: rtl/msdap_conv_sequencer.sv
// Per-channel convolution scheduler for the MSDAP filter datapath.
// On start it walks the 16 Rj groups, fetches each group's coefficients,
// reads the matching history sample x(n-k) from the circular data buffer
// and shift-and-adds into a 40-bit accumulator (one arithmetic right
// shift per group).
// Ports:
//   sClk, reset     : clock, asynchronous active-high reset
//   clear           : synchronous abort to IDLE, result is kept
//   start           : one-cycle request, ignored unless IDLE
//   n_in            : current sample index n
//   newest_ptr      : data buffer address holding x(n)
//   mem             : Rj / coefficient / data buffer read bus (master)
//   busy, done      : busy from acceptance until done; done is one cycle
//   result          : y(n), held until the next done
//   coeff_overrun   : sticky, Rj sum walked past the coefficient memory
module msdap_conv_sequencer (
  input  logic                          sClk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          start,
  input  logic [15:0]                   n_in,
  input  logic [7:0]                    newest_ptr,
  msdap_conv_sequencer_if.master        mem,
  output logic                          busy,
  output logic                          done,
  output logic [39:0]                   result,
  output logic                          coeff_overrun
);

  localparam int unsigned RJ_NUM    = 16;
  localparam int unsigned COEFF_NUM = 512;
  localparam int unsigned DATA_NUM  = 256;
  localparam int unsigned ACC_W     = 40;
  localparam int unsigned FRAC_SH   = 16;
  localparam int unsigned SAMP_W    = 16;
  localparam int unsigned J_W       = $clog2(RJ_NUM);
  // One extra bit so the pointer can sit at COEFF_NUM to flag overrun.
  localparam int unsigned CP_W      = $clog2(COEFF_NUM) + 1;
  localparam int unsigned DA_W      = $clog2(DATA_NUM);
  localparam int unsigned EXT_W     = ACC_W - SAMP_W - FRAC_SH;

  typedef enum logic [2:0] {
    IDLE, RJ_FETCH, RJ_LATCH, COEF_FETCH, COEF_LATCH, DATA_ACC, SHIFT, DONE
  } state_t;

  state_t            state;
  logic [15:0]       nLat;
  logic [15:0]       rCnt;
  logic [DA_W-1:0]   newestLat;
  logic [J_W-1:0]    jCnt;
  logic [CP_W-1:0]   coeffPtr;
  logic [ACC_W-1:0]  acc;
  logic              termRead;
  logic              termSub;

  logic              termOvr;
  logic [CP_W-1:0]   ptrNext;
  logic [7:0]        offK;
  logic [ACC_W-1:0]  termVal;
  logic [ACC_W-1:0]  accShr;
  logic [6:0]        unusedCoeffHi;

  // Pointer saturates at COEFF_NUM; any term fetched there is an overrun.
  assign termOvr       = coeffPtr[CP_W-1];
  assign ptrNext       = termOvr ? coeffPtr : coeffPtr + CP_W'(1);
  assign offK          = mem.coeff_data[7:0];
  assign unusedCoeffHi = mem.coeff_data[15:9];
  assign termVal       = {{EXT_W{mem.data_rd[SAMP_W-1]}}, mem.data_rd, {FRAC_SH{1'b0}}};
  assign accShr        = ACC_W'($signed(acc) >>> 1);

  // Data read is decoded from coeff_data in the same cycle it arrives so
  // the sample is back in time for DATA_ACC.
  always_comb begin
    mem.data_rd_en = 1'b0;
    mem.data_addr  = '0;
    if (state == COEF_LATCH && !termOvr && 16'(offK) <= nLat) begin
      mem.data_rd_en = 1'b1;
      mem.data_addr  = newestLat - offK;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge sClk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      nLat           <= '0;
      rCnt           <= '0;
      newestLat      <= '0;
      jCnt           <= '0;
      coeffPtr       <= '0;
      acc            <= '0;
      termRead       <= 1'b0;
      termSub        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      result         <= '0;
      coeff_overrun  <= 1'b0;
      mem.rj_addr    <= '0;
      mem.coeff_addr <= '0;
    end else if (clear) begin
      // Abort without touching result.
      state          <= IDLE;
      rCnt           <= '0;
      jCnt           <= '0;
      coeffPtr       <= '0;
      acc            <= '0;
      termRead       <= 1'b0;
      termSub        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      coeff_overrun  <= 1'b0;
      mem.rj_addr    <= '0;
      mem.coeff_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nLat        <= n_in;
            newestLat   <= newest_ptr;
            acc         <= '0;
            coeffPtr    <= '0;
            jCnt        <= '0;
            mem.rj_addr <= '0;
            busy        <= 1'b1;
            state       <= RJ_FETCH;
          end
        end
        RJ_FETCH: state <= RJ_LATCH;
        RJ_LATCH: begin
          rCnt <= mem.rj_data;
          if (mem.rj_data == 16'd0) begin
            state <= SHIFT;
          end else begin
            if (!termOvr) mem.coeff_addr <= coeffPtr[CP_W-2:0];
            state <= COEF_FETCH;
          end
        end
        COEF_FETCH: begin
          if (termOvr) coeff_overrun <= 1'b1;
          state <= COEF_LATCH;
        end
        COEF_LATCH: begin
          termRead <= mem.data_rd_en;
          termSub  <= mem.coeff_data[8];
          state    <= DATA_ACC;
        end
        DATA_ACC: begin
          if (termRead) acc <= termSub ? acc - termVal : acc + termVal;
          coeffPtr <= ptrNext;
          rCnt     <= rCnt - 16'd1;
          if (rCnt == 16'd1) begin
            state <= SHIFT;
          end else begin
            if (!ptrNext[CP_W-1]) mem.coeff_addr <= ptrNext[CP_W-2:0];
            state <= COEF_FETCH;
          end
        end
        SHIFT: begin
          acc <= accShr;
          if (jCnt == J_W'(RJ_NUM - 1)) begin
            result <= accShr;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            jCnt        <= jCnt + J_W'(1);
            mem.rj_addr <= jCnt + J_W'(1);
            state       <= RJ_FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msdap_conv_sequencer.sv
// Scoreboard bench for msdap_conv_sequencer: directed runs push expected
// result/latency and expected data-buffer addresses; a negedge monitor
// pops and compares whenever the DUT reads or signals done.
module tb_msdap_conv_sequencer;

  logic        sClk = 1'b0;
  logic        reset;
  logic        clear;
  logic        start;
  logic [15:0] n_in;
  logic [7:0]  newest_ptr;
  logic        busy;
  logic        done;
  logic [39:0] result;
  logic        coeff_overrun;

  msdap_conv_sequencer_if memIf ();

  msdap_conv_sequencer dut (
    .sClk          (sClk),
    .reset         (reset),
    .clear         (clear),
    .start         (start),
    .n_in          (n_in),
    .newest_ptr    (newest_ptr),
    .mem           (memIf.master),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .coeff_overrun (coeff_overrun)
  );

  always #5 sClk = ~sClk;

  logic [15:0] rjMem    [16];
  logic [15:0] coeffMem [512];
  logic [15:0] dataMem  [256];

  // Synchronous-read memory models.
  always @(posedge sClk) begin
    memIf.rj_data    <= rjMem[memIf.rj_addr];
    memIf.coeff_data <= coeffMem[memIf.coeff_addr];
    if (memIf.data_rd_en) memIf.data_rd <= dataMem[memIf.data_addr];
  end

  int cyc = 0;
  always @(posedge sClk) cyc <= cyc + 1;

  typedef struct {
    logic [39:0] res;
    int          lat;
    int          startCyc;
  } exp_t;

  exp_t        expQ [$];
  logic [7:0]  addrQ [$];
  int          nChecks = 0;
  int          nFails  = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  // Monitor: compare every data read and every done against the scoreboard.
  exp_t       monExp;
  logic [7:0] monAddr;
  always @(negedge sClk) begin
    if (!reset) begin
      if (memIf.data_rd_en) begin
        if (addrQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpected data read: got addr 0x%0h, required no read", memIf.data_addr);
        end else begin
          monAddr = addrQ.pop_front();
          check("data_addr", 64'(memIf.data_addr), 64'(monAddr));
        end
      end
      if (done) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpected done: got result 0x%0h, required no done", result);
        end else begin
          monExp = expQ.pop_front();
          check("result", 64'(result), 64'(monExp.res));
          check("latency", 64'(cyc - monExp.startCyc), 64'(monExp.lat));
          check("reads outstanding", 64'(addrQ.size()), 64'd0);
        end
      end
    end
  end

  task automatic runStart(input logic [15:0] n, input logic [7:0] ptr,
                          input logic [39:0] res, input int lat);
    @(negedge sClk);
    n_in       = n;
    newest_ptr = ptr;
    start      = 1'b1;
    expQ.push_back('{res, lat, cyc});
    @(negedge sClk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while (expQ.size() != 0 && k < budget) begin
      @(negedge sClk);
      k++;
    end
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("FAIL done timeout: got no done in %0d cycles, required done", budget);
      expQ.delete();
      addrQ.delete();
    end
  endtask

  task automatic zeroMems();
    for (int i = 0; i < 16; i++)  rjMem[i]    = 16'h0;
    for (int i = 0; i < 512; i++) coeffMem[i] = 16'h0;
    for (int i = 0; i < 256; i++) dataMem[i]  = 16'h0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; start = 1'b0; n_in = '0; newest_ptr = '0;
    zeroMems();
    repeat (3) @(negedge sClk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset overrun", 64'(coeff_overrun), 64'd0);
    check("reset data_rd_en", 64'(memIf.data_rd_en), 64'd0);
    check("reset rj_addr", 64'(memIf.rj_addr), 64'd0);
    check("reset coeff_addr", 64'(memIf.coeff_addr), 64'd0);
    check("reset data_addr", 64'(memIf.data_addr), 64'd0);
    reset = 1'b0;

    // All Rj zero: empty walk, 49 cycles.
    runStart(16'd0, 8'h10, 40'h0, 49);
    waitIdle(200);

    // Single positive term in group 0: 0x0100<<16 then 16 shifts.
    rjMem[0] = 16'd1; dataMem[8'h0A] = 16'h0100;
    addrQ.push_back(8'h0A);
    runStart(16'd0, 8'h0A, 40'h0000000100, 52);
    waitIdle(200);

    // Same term subtracted.
    coeffMem[0] = 16'h0100;
    addrQ.push_back(8'h0A);
    runStart(16'd0, 8'h0A, 40'hFFFFFFFF00, 52);
    waitIdle(200);

    // Term only in the last group: one shift.
    coeffMem[0] = 16'h0000; rjMem[0] = 16'd0; rjMem[15] = 16'd1;
    addrQ.push_back(8'h0A);
    runStart(16'd0, 8'h0A, 40'h0000800000, 52);
    waitIdle(200);

    // Most negative sample: -2^31 >>> 1.
    dataMem[8'h30] = 16'h8000;
    addrQ.push_back(8'h30);
    runStart(16'd0, 8'h30, 40'hFFC0000000, 52);
    waitIdle(200);

    // k > n: no read, term contributes zero, timing unchanged.
    rjMem[15] = 16'd0; rjMem[0] = 16'd1; coeffMem[0] = 16'h0005;
    runStart(16'd3, 8'h0A, 40'h0, 52);
    waitIdle(200);

    // k == n: read allowed, addr 0x0A-5.
    dataMem[8'h05] = 16'h0040;
    addrQ.push_back(8'h05);
    runStart(16'd5, 8'h0A, 40'h0000000040, 52);
    waitIdle(200);

    // Wrap-around address: 2 - 5 = 0xFD.
    dataMem[8'hFD] = 16'h0100;
    addrQ.push_back(8'hFD);
    runStart(16'd300, 8'h02, 40'h0000000100, 52);
    waitIdle(200);

    // Two groups: +0x300 in j=0, -0x100 (k=1) in j=1 -> 0x100.
    rjMem[1] = 16'd1; coeffMem[0] = 16'h0000; coeffMem[1] = 16'h0101;
    dataMem[8'd20] = 16'h0300; dataMem[8'd19] = 16'h0100;
    addrQ.push_back(8'd20); addrQ.push_back(8'd19);
    runStart(16'd5, 8'd20, 40'h0000000100, 55);
    begin
      int k = 0;
      while (!done && k < 200) begin
        @(negedge sClk);
        k++;
      end
    end
    // Start in the DONE cycle is ignored; start in the next cycle is taken.
    start = 1'b1; n_in = 16'hFFFF; newest_ptr = 8'd20;
    @(negedge sClk);
    n_in = 16'd0;
    addrQ.push_back(8'd20);
    expQ.push_back('{40'h0000000300, 55, cyc});
    @(negedge sClk);
    start = 1'b0;
    waitIdle(200);

    // Overrun: Rj sum 520, only the first 512 terms read.
    check("overrun before", 64'(coeff_overrun), 64'd0);
    zeroMems();
    rjMem[0] = 16'd520; dataMem[8'h40] = 16'h0001;
    for (int i = 0; i < 512; i++) addrQ.push_back(8'h40);
    runStart(16'd0, 8'h40, 40'h0000000200, 1609);
    repeat (100) @(negedge sClk);
    check("busy mid-run", 64'(busy), 64'd1);
    start = 1'b1; n_in = 16'd7;
    @(negedge sClk);
    start = 1'b0;
    waitIdle(2000);
    check("overrun sticky", 64'(coeff_overrun), 64'd1);

    // Clear mid-run: abort, no done, result kept, overrun cleared.
    rjMem[0] = 16'd0;
    @(negedge sClk);
    start = 1'b1; n_in = 16'd0;
    @(negedge sClk);
    start = 1'b0;
    repeat (20) @(negedge sClk);
    clear = 1'b1;
    @(negedge sClk);
    clear = 1'b0;
    check("clear busy", 64'(busy), 64'd0);
    check("clear result kept", 64'(result), 64'h0000000200);
    check("clear overrun", 64'(coeff_overrun), 64'd0);
    repeat (60) @(negedge sClk);
    check("busy after clear", 64'(busy), 64'd0);

    // Fresh run after clear.
    runStart(16'd0, 8'h10, 40'h0, 49);
    waitIdle(200);

    // Nonzero result, then async reset mid-run zeroes it at once.
    rjMem[0] = 16'd1; dataMem[8'h0A] = 16'h0100;
    addrQ.push_back(8'h0A);
    runStart(16'd0, 8'h0A, 40'h0000000100, 52);
    waitIdle(200);
    rjMem[0] = 16'd0;
    @(negedge sClk);
    start = 1'b1;
    @(negedge sClk);
    start = 1'b0;
    repeat (10) @(negedge sClk);
    #2 reset = 1'b1;
    #1;
    check("reset mid-run result", 64'(result), 64'd0);
    check("reset mid-run busy", 64'(busy), 64'd0);
    @(negedge sClk);
    reset = 1'b0;
    repeat (60) @(negedge sClk);
    check("busy after reset", 64'(busy), 64'd0);
    check("no pending expectations", 64'(expQ.size() + addrQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
